c2h_pattern_tx: RTL and testbench
=================================

Name: c2h_pattern_tx

Overview:
AXI4-Stream transmitter that drives the XDMA C2H stream port (s_axis_c2h_*_0) from the user side. It sends frames of a deterministic incrementing 32-bit word pattern, each frame of programmable byte length. After each frame it can raise a user interrupt and hold it until the XDMA acknowledges it. The block sits inside the application layer in the user_clk domain, alongside the H2C receive logic, and is used for C2H throughput and integrity testing.

Parameters:
TCQ, 1, simulation clock-to-q delay applied on all register assignments
DATA_WIDTH, 128, stream data width in bits; must be a multiple of 32 and at least 64
IRQ_WIDTH, 1, width of the irq request and acknowledge vectors
BYTE_BIT_ENABLE, DATA_WIDTH/8, tkeep width in bits
LEN_WIDTH, 16, width of the frame byte count

Ports:
user_clk  in  1  XDMA axi_aclk; the only clock
user_rst  in  1  synchronous, active-high reset
enable  in  1  level input; while high in IDLE, a new frame starts
irq_en  in  1  when high, an interrupt handshake follows each frame
frame_bytes  in  LEN_WIDTH  frame length in bytes; sampled only at frame start
m_axis_c2h_tdata  out  DATA_WIDTH  pattern data
m_axis_c2h_tkeep  out  BYTE_BIT_ENABLE  byte enables
m_axis_c2h_tlast  out  1  marks the final beat of a frame
m_axis_c2h_tvalid  out  1  beat valid
m_axis_c2h_tready  in  1  XDMA ready
irq_req  out  IRQ_WIDTH  interrupt request; only bit 0 is used, other bits are tied to 0
irq_ack  in  IRQ_WIDTH  XDMA interrupt acknowledge; only bit 0 is sampled
frame_cnt  out  32  count of completed frames; wraps at 2^32
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, user_clk. Reset user_rst is synchronous and active-high.
- Reset state: state=IDLE. tvalid, tlast, irq_req, busy, frame_cnt and the word counter are all 0. tdata=0, tkeep=0. Reset takes priority over every other event, including in the middle of a frame or an IRQ; tvalid drops on the next edge.
- States: IDLE, SEND, IRQ.
- IDLE: if enable=1 and frame_bytes!=0 in cycle N:
  - latch len=frame_bytes;
  - compute beats=ceil(len/BYTE_BIT_ENABLE);
  - compute rem=len mod BYTE_BIT_ENABLE;
  - move to SEND, with tvalid=1 and the first beat presented at N+1.
- IDLE with frame_bytes=0: the block stays in IDLE; no zero-length frame is ever sent.
- Beat content: tdata lane i (bits 32i+31:32i) = word_cnt+i, for i = 0 .. DATA_WIDTH/32-1. word_cnt advances by DATA_WIDTH/32 per accepted beat, is 32-bit modulo (wrap-around is legal), and continues across frames; it is cleared only by reset.
- tkeep and tlast: tkeep is all ones except on the last beat. On the last beat, tkeep = the low rem bits set, or all ones if rem=0. tlast=1 only on the last beat. tdata lanes beyond len still carry the pattern.
- AXIS rules:
  - a beat transfers on tvalid&tready;
  - while tvalid=1 and tready=0, tdata, tkeep and tlast are held stable;
  - tvalid never drops mid-frame; back-to-back beats run at one per cycle when tready=1.
- End of frame: on the last-beat handshake in cycle N, frame_cnt increments, visible at N+1.
  - If irq_en=1 (sampled at N), the block moves to IRQ with irq_req[0]=1 at N+1 and tvalid=0.
  - Otherwise it returns to IDLE at N+1. The earliest next tvalid is N+2.
- IRQ: irq_req[0] is held high until irq_ack[0]=1 is seen (cycle M). At M+1, irq_req=0 and state=IDLE. irq_ack outside the IRQ state is ignored.
- enable dropping mid-frame or during IRQ: the current frame and its handshake complete; no further frame starts.
- Changes to frame_bytes or irq_en mid-frame are ignored (both are latched or sampled as above).

Decomposition:
- Package dma_app_pkg holds:
  - the state encoding (IDLE, SEND, IRQ);
  - LANES = DATA_WIDTH/32;
  - KEEP_SHIFT = log2(BYTE_BIT_ENABLE);
  - a function keep_mask(rem) returning the last-beat tkeep.
- No sub-module is needed; the FSM, beat counter and pattern datapath live in a single module.

Test Plan:
- Single frame, 128-bit: frame_bytes=40, irq_en=0, tready=1 -> 3 beats; lanes {3,2,1,0}, {7,6,5,4}, {11,10,9,8}; last tkeep=16'h00FF with tlast=1; frame_cnt=1.
- Backpressure: frame_bytes=64 with tready toggled 1,0,0,1,... -> 4 beats; data held stable while stalled; no beat lost or duplicated; next frame starts at word 16.
- Interrupt: irq_en=1, frame_bytes=16, irq_ack pulsed 5 cycles after irq_req rises -> irq_req high for exactly 6 cycles; no tvalid while in IRQ; next frame starts 2 cycles after the ack.
- Boundaries: frame_bytes=0 -> tvalid never asserts. frame_bytes=32 -> last tkeep=16'hFFFF. frame_bytes=1 -> a single beat with tkeep=16'h0001 and tlast=1.
- Reset mid-frame: assert user_rst on beat 2 of 4 -> tvalid, irq_req and frame_cnt are 0 at the next edge; after release the first beat carries lanes {3,2,1,0}.
- Continuity: three 48-byte frames back-to-back with irq_en=0 -> word_cnt continuous across frames (0 to 35); frame_cnt=3; exactly one cycle with tvalid=0 between frames.

Source files
------------

// File: rtl/c2h_pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dma_app_pkg
//  Brief   : Shared types and helpers for the C2H pattern transmitter:
//            FSM state encoding, lane/keep sizing helpers, last-beat tkeep.
//  Revision: 1.0 - initial release
// ============================================================================
package dma_app_pkg;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_IRQ  = 2'd2
    } state_t;

    // Widest tkeep the helpers support (1024-bit stream)
    localparam int unsigned KEEP_MAX = 128;

    // Number of 32-bit pattern lanes in one beat (LANES)
    function automatic int unsigned lanes_of(input int unsigned data_width);
        return data_width / 32;
    endfunction

    // Shift converting a byte count to a beat count (KEEP_SHIFT)
    function automatic int unsigned keep_shift_of(input int unsigned nbytes);
        return $clog2(nbytes);
    endfunction

    // Last-beat tkeep: low rem bits set, or a full beat when rem is zero
    function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned rem,
                                                      input int unsigned nbytes);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if ((rem == 0 && i < nbytes) || (rem != 0 && i < rem)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c2h_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module  : c2h_pattern_tx
//  Brief   : AXI4-Stream source for the XDMA C2H port. Emits frames of an
//            incrementing 32-bit word pattern of programmable byte length,
//            optionally followed by a user-interrupt handshake.
//  Revision: 1.0 - initial release
// ============================================================================
module c2h_pattern_tx
    import dma_app_pkg::*;
#(
    parameter int TCQ             = 1,
    parameter int DATA_WIDTH      = 128,
    parameter int IRQ_WIDTH       = 1,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       user_clk,
    input  logic                       user_rst,
    input  logic                       enable,
    input  logic                       irq_en,
    input  logic [LEN_WIDTH-1:0]       frame_bytes,
    output logic [DATA_WIDTH-1:0]      m_axis_c2h_tdata,
    output logic [BYTE_BIT_ENABLE-1:0] m_axis_c2h_tkeep,
    output logic                       m_axis_c2h_tlast,
    output logic                       m_axis_c2h_tvalid,
    input  logic                       m_axis_c2h_tready,
    output logic [IRQ_WIDTH-1:0]       irq_req,
    input  logic [IRQ_WIDTH-1:0]       irq_ack,
    output logic [31:0]                frame_cnt,
    output logic                       busy
);

    localparam int unsigned c_lanes      = lanes_of(DATA_WIDTH);
    localparam int unsigned c_keep_shift = keep_shift_of(BYTE_BIT_ENABLE);
    localparam logic [BYTE_BIT_ENABLE-1:0] c_keep_all = {BYTE_BIT_ENABLE{1'b1}};
    localparam logic [LEN_WIDTH:0] c_one = (LEN_WIDTH+1)'(1);
    localparam logic [LEN_WIDTH:0] c_two = (LEN_WIDTH+1)'(2);

    state_t                       r_state;
    logic [31:0]                  r_word_cnt;
    logic [31:0]                  r_frame_cnt;
    logic [LEN_WIDTH:0]           r_beats_left;
    logic [BYTE_BIT_ENABLE-1:0]   r_last_keep;
    logic [DATA_WIDTH-1:0]        r_tdata;
    logic [BYTE_BIT_ENABLE-1:0]   r_tkeep;
    logic                         r_tlast;
    logic                         r_tvalid;
    logic                         r_irq;

    logic [LEN_WIDTH:0]           w_len_round;
    logic [LEN_WIDTH:0]           w_beats;
    logic [c_keep_shift-1:0]      w_rem;
    logic [BYTE_BIT_ENABLE-1:0]   w_last_keep;
    logic [31:0]                  w_base;
    logic [DATA_WIDTH-1:0]        w_pattern;
    logic                         w_start;
    logic                         w_accept;

    // The clock-to-q parameter is kept for interface compatibility only
    logic [31:0] unused_tcq;
    assign unused_tcq = 32'(TCQ);

    // Frame geometry derived from the requested length at frame start
    assign w_len_round = {1'b0, frame_bytes} + (LEN_WIDTH+1)'(BYTE_BIT_ENABLE - 1);
    assign w_beats     = w_len_round >> c_keep_shift;
    assign w_rem       = frame_bytes[c_keep_shift-1:0];
    assign w_last_keep = BYTE_BIT_ENABLE'(keep_mask(32'(w_rem), BYTE_BIT_ENABLE));

    assign w_start  = enable && (frame_bytes != '0);
    assign w_accept = r_tvalid && m_axis_c2h_tready;

    // First beat of a frame uses the current word; later beats look one beat ahead
    assign w_base = (r_state == ST_IDLE) ? r_word_cnt : (r_word_cnt + 32'(c_lanes));

    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        assign w_pattern[32*g +: 32] = w_base + 32'(g);
    end

    if (IRQ_WIDTH > 1) begin : g_ack_upper
        logic unused_ack_upper;
        assign unused_ack_upper = ^irq_ack[IRQ_WIDTH-1:1];
    end

    // Frame sequencer: start, beat stepping under backpressure, IRQ handshake
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_beats_left <= '0;
            r_last_keep  <= '0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tvalid     <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state      <= ST_SEND;
                        r_tvalid     <= 1'b1;
                        r_tdata      <= w_pattern;
                        r_beats_left <= w_beats;
                        r_last_keep  <= w_last_keep;
                        r_tlast      <= (w_beats == c_one);
                        r_tkeep      <= (w_beats == c_one) ? w_last_keep : c_keep_all;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_word_cnt <= r_word_cnt + 32'(c_lanes);
                        if (r_tlast) begin
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 32'd1;
                            if (irq_en) begin
                                r_state <= ST_IRQ;
                                r_irq   <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_beats_left <= r_beats_left - c_one;
                            r_tdata      <= w_pattern;
                            r_tlast      <= (r_beats_left == c_two);
                            r_tkeep      <= (r_beats_left == c_two) ? r_last_keep : c_keep_all;
                        end
                    end
                end
                ST_IRQ: begin
                    if (irq_ack[0]) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_c2h_tdata  = r_tdata;
    assign m_axis_c2h_tkeep  = r_tkeep;
    assign m_axis_c2h_tlast  = r_tlast;
    assign m_axis_c2h_tvalid = r_tvalid;
    assign irq_req           = IRQ_WIDTH'(r_irq);
    assign frame_cnt         = r_frame_cnt;
    assign busy              = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_c2h_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_c2h_pattern_tx
//  Brief   : Directed self-checking bench for c2h_pattern_tx (128-bit).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_c2h_pattern_tx;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         irq_en;
    logic [15:0]  frame_bytes;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic [0:0]   irq_req;
    logic [0:0]   irq_ack;
    logic [31:0]  frame_cnt;
    logic         busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_word;
    logic [31:0] exp_frames;

    c2h_pattern_tx dut (
        .user_clk          (clk),
        .user_rst          (rst),
        .enable            (enable),
        .irq_en            (irq_en),
        .frame_bytes       (frame_bytes),
        .m_axis_c2h_tdata  (tdata),
        .m_axis_c2h_tkeep  (tkeep),
        .m_axis_c2h_tlast  (tlast),
        .m_axis_c2h_tvalid (tvalid),
        .m_axis_c2h_tready (tready),
        .irq_req           (irq_req),
        .irq_ack           (irq_ack),
        .frame_cnt         (frame_cnt),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    // Expected beat for a given starting word: lanes {w+3, w+2, w+1, w}
    function automatic logic [127:0] pat(input logic [31:0] w);
        return {w + 32'd3, w + 32'd2, w + 32'd1, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        exp_word   = 32'd0;
        exp_frames = 32'd0;
    endtask

    // One-cycle enable pulse; the first beat is visible on return
    task automatic pulse_start(input logic [15:0] nbytes, input logic ie);
        frame_bytes = nbytes;
        irq_en      = ie;
        enable      = 1'b1;
        tick();
        enable      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; irq_en = 1'b0; frame_bytes = '0;
        tready = 1'b1; irq_ack = 1'b0;
        repeat (3) tick();
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tvalid=%b tlast=%b busy=%b required 0 0 0", tvalid, tlast, busy);
        end
        checks++;
        if (tdata !== 128'd0 || tkeep !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tkeep=%h required 0 0", tdata, tkeep);
        end
        checks++;
        if (irq_req !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt: irq_req=%b frame_cnt=%0d required 0 0", irq_req, frame_cnt);
        end
        rst = 1'b0;
        tick();
        exp_word = 32'd0;
        exp_frames = 32'd0;
    endtask

    task automatic test_single_frame();
        logic [15:0] kexp;
        tready = 1'b1;
        pulse_start(16'd40, 1'b0);
        for (int b = 0; b < 3; b++) begin
            kexp = (b == 2) ? 16'h00FF : 16'hFFFF;
            checks++;
            if (tvalid !== 1'b1 || tdata !== pat(exp_word)) begin
                errors++;
                $display("FAIL single_data beat%0d: tvalid=%b tdata=%h required 1 %h", b, tvalid, tdata, pat(exp_word));
            end
            checks++;
            if (tkeep !== kexp || tlast !== (b == 2)) begin
                errors++;
                $display("FAIL single_keep beat%0d: tkeep=%h tlast=%b required %h %b", b, tkeep, tlast, kexp, (b == 2));
            end
            exp_word += 32'd4;
            tick();
        end
        exp_frames++;
        checks++;
        if (tvalid !== 1'b0 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_end: tvalid=%b frame_cnt=%0d required 0 1", tvalid, frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        int beats;
        logic prev_acc;
        logic have_prev;
        logic [127:0] prev_data;
        logic prev_last;
        do_reset();
        beats = 0; prev_acc = 1'b1; have_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
        tready = 1'b1;
        pulse_start(16'd64, 1'b0);
        for (int c = 0; c < 30 && beats < 4; c++) begin
            tready = (c % 3 == 0);
            if (tvalid === 1'b1) begin
                if (have_prev && !prev_acc) begin
                    checks++;
                    if (tdata !== prev_data || tlast !== prev_last) begin
                        errors++;
                        $display("FAIL bp_hold cyc%0d: tdata=%h tlast=%b required %h %b", c, tdata, tlast, prev_data, prev_last);
                    end
                end
                if (tready) begin
                    checks++;
                    if (tdata !== pat(exp_word) || tlast !== (beats == 3)) begin
                        errors++;
                        $display("FAIL bp_beat%0d: tdata=%h tlast=%b required %h %b", beats, tdata, tlast, pat(exp_word), (beats == 3));
                    end
                    exp_word += 32'd4;
                    beats++;
                    prev_acc = 1'b1;
                end else begin
                    prev_acc = 1'b0;
                end
                prev_data = tdata;
                prev_last = tlast;
                have_prev = 1'b1;
            end
            tick();
        end
        tready = 1'b1;
        exp_frames++;
        checks++;
        if (beats != 4 || tvalid !== 1'b0 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL bp_end: beats=%0d tvalid=%b frame_cnt=%0d required 4 0 1", beats, tvalid, frame_cnt);
        end
        pulse_start(16'd16, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tdata[31:0] !== 32'd16) begin
            errors++;
            $display("FAIL bp_next_word: tvalid=%b lane0=%0d required 1 16", tvalid, tdata[31:0]);
        end
        tick();
        exp_word += 32'd4;
        exp_frames++;
    endtask

    task automatic test_irq();
        tready = 1'b1; frame_bytes = 16'd16; irq_en = 1'b1; enable = 1'b1;
        tick();
        checks++;
        if (tvalid !== 1'b1 || tdata !== pat(exp_word) || tlast !== 1'b1) begin
            errors++;
            $display("FAIL irq_beat: tvalid=%b tdata=%h tlast=%b required 1 %h 1", tvalid, tdata, tlast, pat(exp_word));
        end
        exp_word += 32'd4;
        tick();
        exp_frames++;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (irq_req !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL irq_hold cyc%0d: irq_req=%b tvalid=%b busy=%b required 1 0 1", k, irq_req, tvalid, busy);
            end
            if (k == 5) irq_ack = 1'b1;
            tick();
        end
        irq_ack = 1'b0;
        irq_en  = 1'b0;
        checks++;
        if (irq_req !== 1'b0 || tvalid !== 1'b0 || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL irq_release: irq_req=%b tvalid=%b frame_cnt=%0d required 0 0 %0d", irq_req, tvalid, frame_cnt, exp_frames);
        end
        tick();
        checks++;
        if (tvalid !== 1'b1 || tdata !== pat(exp_word)) begin
            errors++;
            $display("FAIL irq_restart: tvalid=%b tdata=%h required 1 %h", tvalid, tdata, pat(exp_word));
        end
        enable = 1'b0;
        exp_word += 32'd4;
        tick();
        exp_frames++;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        checks++;
        if (tvalid !== 1'b0 || irq_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL irq_idle_ack: tvalid=%b irq_req=%b busy=%b required 0 0 0", tvalid, irq_req, busy);
        end
    endtask

    task automatic test_boundaries();
        int bad;
        bad = 0;
        frame_bytes = 16'd0; irq_en = 1'b0; enable = 1'b1; tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (tvalid !== 1'b0 || busy !== 1'b0) bad++;
        end
        enable = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL zero_len: active_cycles=%0d required 0", bad);
        end
        pulse_start(16'd32, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tkeep !== 16'hFFFF || tlast !== 1'b0 || tdata !== pat(exp_word)) begin
            errors++;
            $display("FAIL len32_b0: tvalid=%b tkeep=%h tlast=%b tdata=%h", tvalid, tkeep, tlast, tdata);
        end
        exp_word += 32'd4;
        tick();
        checks++;
        if (tvalid !== 1'b1 || tkeep !== 16'hFFFF || tlast !== 1'b1 || tdata !== pat(exp_word)) begin
            errors++;
            $display("FAIL len32_b1: tvalid=%b tkeep=%h tlast=%b tdata=%h required tkeep ffff tlast 1", tvalid, tkeep, tlast, tdata);
        end
        exp_word += 32'd4;
        tick();
        exp_frames++;
        pulse_start(16'd1, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tkeep !== 16'h0001 || tlast !== 1'b1 || tdata !== pat(exp_word)) begin
            errors++;
            $display("FAIL len1: tvalid=%b tkeep=%h tlast=%b tdata=%h required 1 0001 1 %h", tvalid, tkeep, tlast, tdata, pat(exp_word));
        end
        exp_word += 32'd4;
        tick();
        exp_frames++;
        checks++;
        if (tvalid !== 1'b0 || frame_cnt !== exp_frames) begin
            errors++;
            $display("FAIL len1_end: tvalid=%b frame_cnt=%0d required 0 %0d", tvalid, frame_cnt, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        tready = 1'b1;
        pulse_start(16'd64, 1'b0);
        tick();
        checks++;
        if (tvalid !== 1'b1 || tdata !== pat(exp_word + 32'd4)) begin
            errors++;
            $display("FAIL rstmid_beat2: tvalid=%b tdata=%h required 1 %h", tvalid, tdata, pat(exp_word + 32'd4));
        end
        rst = 1'b1;
        tick();
        checks++;
        if (tvalid !== 1'b0 || irq_req !== 1'b0 || frame_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_clear: tvalid=%b irq_req=%b frame_cnt=%0d required 0 0 0", tvalid, irq_req, frame_cnt);
        end
        rst = 1'b0;
        tick();
        pulse_start(16'd16, 1'b0);
        checks++;
        if (tvalid !== 1'b1 || tdata !== 128'h00000003_00000002_00000001_00000000) begin
            errors++;
            $display("FAIL rstmid_restart: tvalid=%b tdata=%h required 1 00000003000000020000000100000000", tvalid, tdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int beats;
        int gap_len;
        int gaps;
        do_reset();
        beats = 0; gap_len = 0; gaps = 0;
        frame_bytes = 16'd48; irq_en = 1'b0; tready = 1'b1; enable = 1'b1;
        tick();
        for (int c = 0; c < 40 && beats < 9; c++) begin
            if (tvalid === 1'b1) begin
                if (gap_len > 0) begin
                    gaps++;
                    checks++;
                    if (gap_len != 1) begin
                        errors++;
                        $display("FAIL b2b_gap%0d: idle_cycles=%0d required 1", gaps, gap_len);
                    end
                    gap_len = 0;
                end
                checks++;
                if (tdata !== pat(exp_word) || tkeep !== 16'hFFFF || tlast !== (beats % 3 == 2)) begin
                    errors++;
                    $display("FAIL b2b_beat%0d: tdata=%h tkeep=%h tlast=%b required %h ffff %b", beats, tdata, tkeep, tlast, pat(exp_word), (beats % 3 == 2));
                end
                exp_word += 32'd4;
                beats++;
                if (beats == 7) enable = 1'b0;
            end else begin
                gap_len++;
            end
            tick();
        end
        enable = 1'b0;
        checks++;
        if (beats != 9 || gaps != 2 || frame_cnt !== 32'd3 || exp_word !== 32'd36) begin
            errors++;
            $display("FAIL b2b_end: beats=%0d gaps=%0d frame_cnt=%0d next_word=%0d required 9 2 3 36", beats, gaps, frame_cnt, exp_word);
        end
        tick();
        tick();
        checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop: tvalid=%b busy=%b required 0 0", tvalid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_irq();
        test_boundaries();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case any sequence stalls unexpectedly
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
